sprite_layer_scheduler: RTL and testbench

SPRITE_LAYER_SCHEDULER -- requirements
Module: sprite_layer_scheduler

---
 rtl/sprite_layer_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_sprite_layer_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_scheduler.sv
// rtl/sprite_layer_scheduler.sv - sprite slot scheduler with shadow/active tables; optional overlap flag under SPRITE_SCHED_COLLISION_EN
module sprite_layer_scheduler #(
  parameter int NSLOT = 4,
  parameter int SW    = 63,
  parameter int SH    = 63
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [9:0]        pixelx,
  input  logic signed [9:0]        pixely,
  input  logic                     pixel_valid,
  input  logic                     frame_start,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(NSLOT)-1:0] wr_slot,
  input  logic signed [9:0]        wr_posx,
  input  logic signed [9:0]        wr_posy,
  input  logic                     wr_en,
  output logic [11:0]              address,
  output logic [$clog2(NSLOT)-1:0] slot_id,
  output logic                     hit,
  output logic                     collision
);

  localparam int SLW = $clog2(NSLOT);
  localparam logic signed [10:0] SW_S = 11'(SW);
  localparam logic signed [10:0] SH_S = 11'(SH);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [SLW-1:0]  cnt_q, cnt_d;
  logic            copy_en;

  logic signed [9:0] sh_x_q [NSLOT];
  logic signed [9:0] sh_y_q [NSLOT];
  logic              sh_en_q [NSLOT];
  logic signed [9:0] ac_x_q [NSLOT];
  logic signed [9:0] ac_y_q [NSLOT];
  logic              ac_en_q [NSLOT];

  logic signed [10:0] dx_c [NSLOT];
  logic signed [10:0] dy_c [NSLOT];
  logic [NSLOT-1:0]   inb_c;
  logic [11:0]        addr_c [NSLOT];

  logic [NSLOT-1:0]   s1_inb_q;
  logic [11:0]        s1_addr_q [NSLOT];
  logic               s1_valid_q;

  logic               sel_hit;
  logic [SLW-1:0]     sel_id;
  logic [11:0]        sel_addr;

  logic               hit_q;
  logic [SLW-1:0]     slot_id_q;
  logic [11:0]        addr_q;

  logic               wr_fire;
  assign wr_fire = wr_valid && wr_ready;

  // FSM state and commit slot counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE accepts writes, COMMIT walks slots 0..NSLOT-1 once
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ready = 1'b0;
    copy_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ready = 1'b1;
        cnt_d    = '0;
        if (frame_start) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        copy_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == SLW'(NSLOT - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow table takes CPU writes; active table is loaded one slot per commit cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSLOT; k++) begin
        sh_x_q[k]  <= '0;
        sh_y_q[k]  <= '0;
        sh_en_q[k] <= 1'b0;
        ac_x_q[k]  <= '0;
        ac_y_q[k]  <= '0;
        ac_en_q[k] <= 1'b0;
      end
    end else begin
      if (wr_fire) begin
        sh_x_q[wr_slot]  <= wr_posx;
        sh_y_q[wr_slot]  <= wr_posy;
        sh_en_q[wr_slot] <= wr_en;
      end
      if (copy_en) begin
        ac_x_q[cnt_q]  <= sh_x_q[cnt_q];
        ac_y_q[cnt_q]  <= sh_y_q[cnt_q];
        ac_en_q[cnt_q] <= sh_en_q[cnt_q];
      end
    end
  end

  // Per-slot offset and bounds test; sign bit of the 11-bit offset covers pixel < pos
  always_comb begin
    inb_c = '0;
    for (int k = 0; k < NSLOT; k++) begin
      dx_c[k]   = {pixelx[9], pixelx} - {ac_x_q[k][9], ac_x_q[k]};
      dy_c[k]   = {pixely[9], pixely} - {ac_y_q[k][9], ac_y_q[k]};
      inb_c[k]  = ac_en_q[k] && !dx_c[k][10] && !dy_c[k][10] &&
                  (dx_c[k] <= SW_S) && (dy_c[k] <= SH_S);
      addr_c[k] = {dy_c[k][5:0], dx_c[k][5:0]};
    end
  end

  // Stage 1: register per-slot hits and addresses with the pixel qualifier
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_inb_q   <= '0;
      s1_valid_q <= 1'b0;
      for (int k = 0; k < NSLOT; k++) s1_addr_q[k] <= '0;
    end else begin
      s1_inb_q   <= inb_c;
      s1_valid_q <= pixel_valid;
      for (int k = 0; k < NSLOT; k++) s1_addr_q[k] <= addr_c[k];
    end
  end

  // Priority pick: scanning downward leaves the lowest in-bounds slot selected
  always_comb begin
    sel_hit  = 1'b0;
    sel_id   = '0;
    sel_addr = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (s1_inb_q[k]) begin
        sel_hit  = 1'b1;
        sel_id   = SLW'(k);
        sel_addr = s1_addr_q[k];
      end
    end
  end

  // Stage 2: registered outputs, forced to zero without a valid hit
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q     <= 1'b0;
      slot_id_q <= '0;
      addr_q    <= '0;
    end else if (s1_valid_q && sel_hit) begin
      hit_q     <= 1'b1;
      slot_id_q <= sel_id;
      addr_q    <= sel_addr;
    end else begin
      hit_q     <= 1'b0;
      slot_id_q <= '0;
      addr_q    <= '0;
    end
  end

  assign hit     = hit_q;
  assign slot_id = slot_id_q;
  assign address = addr_q;

`ifdef SPRITE_SCHED_COLLISION_EN
  logic coll_q;
  logic multi_c;
  logic start_c;
  assign multi_c = (s1_inb_q & (s1_inb_q - 1'b1)) != '0;
  assign start_c = (state_q == S_IDLE) && frame_start;

  // Sticky overlap flag; a set on the commit-start cycle beats the clear
  always_ff @(posedge clk) begin
    if (reset)                       coll_q <= 1'b0;
    else if (s1_valid_q && multi_c)  coll_q <= 1'b1;
    else if (start_c)                coll_q <= 1'b0;
  end

  assign collision = coll_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// tb/tb_sprite_layer_scheduler.sv - scoreboard bench for sprite_layer_scheduler
module tb_sprite_layer_scheduler;
  localparam int NSLOT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [9:0] pixelx, pixely;
  logic              pixel_valid, frame_start, wr_valid, wr_ready, wr_en;
  logic [1:0]        wr_slot, slot_id;
  logic signed [9:0] wr_posx, wr_posy;
  logic [11:0]       address;
  logic              hit, collision;

  always #5 clk = ~clk;

  sprite_layer_scheduler #(.NSLOT(NSLOT), .SW(63), .SH(63)) dut (
    .clk(clk), .reset(reset), .pixelx(pixelx), .pixely(pixely),
    .pixel_valid(pixel_valid), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
    .wr_posx(wr_posx), .wr_posy(wr_posy), .wr_en(wr_en),
    .address(address), .slot_id(slot_id), .hit(hit), .collision(collision)
  );

  typedef struct packed {
    logic        chk;
    logic        hit;
    logic [1:0]  slot;
    logic [11:0] addr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   sh_x[NSLOT], sh_y[NSLOT], act_x[NSLOT], act_y[NSLOT];
  bit   sh_en[NSLOT], act_en[NSLOT];

`ifdef SPRITE_SCHED_COLLISION_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  function automatic exp_t model(int x, int y, bit v);
    exp_t e;
    e = '{1'b1, 1'b0, 2'd0, 12'd0};
    if (v) begin
      for (int k = NSLOT - 1; k >= 0; k--) begin
        int dx, dy;
        dx = x - act_x[k];
        dy = y - act_y[k];
        if (act_en[k] && dx >= 0 && dy >= 0 && dx <= 63 && dy <= 63) begin
          e.hit  = 1'b1;
          e.slot = 2'(k);
          e.addr = 12'(dy * 64 + dx);
        end
      end
    end
    return e;
  endfunction

  task automatic clk_step(input exp_t e);
    exp_t o;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      o = q.pop_front();
      if (o.chk) begin
        checks++;
        if (hit !== o.hit || slot_id !== o.slot || address !== o.addr) begin
          errors++;
          $display("FAIL pixel_out: got hit=%0b slot=%0d addr=%h, want hit=%0b slot=%0d addr=%h",
                   hit, slot_id, address, o.hit, o.slot, o.addr);
        end
      end
    end
  endtask

  task automatic tick();
    clk_step(model(int'(pixelx), int'(pixely), pixel_valid));
  endtask

  task automatic pix(input int x, input int y, input bit v);
    pixelx = 10'(x); pixely = 10'(y); pixel_valid = v;
    tick();
  endtask

  task automatic pix_exp(input int x, input int y, input bit v,
                         input bit h, input int s, input int a);
    pixelx = 10'(x); pixely = 10'(y); pixel_valid = v;
    clk_step('{1'b1, h, 2'(s), 12'(a)});
  endtask

  task automatic drain();
    pix(0, 0, 0);
    pix(0, 0, 0);
  endtask

  task automatic check_coll(input string name, input bit want);
    checks++;
    if (collision !== want) begin
      errors++;
      $display("FAIL %s: collision=%0b want %0b", name, collision, want);
    end
  endtask

  task automatic write_slot(input int s, input int x, input int y, input bit en);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_slot = 2'(s); wr_posx = 10'(x); wr_posy = 10'(y); wr_en = en;
    while (wr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL write_wait: wr_ready=%0b want 1 within 20 cycles", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    sh_x[s] = x; sh_y[s] = y; sh_en[s] = en;
  endtask

  task automatic do_commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    check_coll("coll_clear_on_commit", 1'b0);
    for (int i = 0; i < NSLOT; i++) begin
      checks++;
      if (wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL commit_ready_low[%0d]: wr_ready=%0b want 0", i, wr_ready);
      end
      tick();
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL commit_ready_back: wr_ready=%0b want 1", wr_ready);
    end
    for (int k = 0; k < NSLOT; k++) begin
      act_x[k] = sh_x[k]; act_y[k] = sh_y[k]; act_en[k] = sh_en[k];
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (wr_ready !== 1'b1 || hit !== 1'b0 || slot_id !== 2'd0 ||
        address !== 12'd0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%0b hit=%0b slot=%0d addr=%h coll=%0b want 1,0,0,000,0",
               name, wr_ready, hit, slot_id, address, collision);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NSLOT; k++) begin
      sh_x[k] = 0; sh_y[k] = 0; sh_en[k] = 0;
      act_x[k] = 0; act_y[k] = 0; act_en[k] = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pixelx = '0; pixely = '0; pixel_valid = 1'b0;
    frame_start = 1'b0; wr_valid = 1'b0; wr_slot = '0;
    wr_posx = '0; wr_posy = '0; wr_en = 1'b0;
    clear_model();
    tick();
    tick();
    reset = 1'b0;
    q.delete();
    check_idle_outputs("reset_state");
  endtask

  task automatic test_basic();
    write_slot(0, 100, 200, 1'b1);
    drain();
    do_commit();
    for (int i = 0; i < 5; i++) tick();
    pix_exp(110, 205, 1'b1, 1'b1, 0, 12'h14A);
    drain();
  endtask

  task automatic test_bounds();
    pix_exp(110, 205, 1'b0, 1'b0, 0, 0);
    pix_exp(164, 205, 1'b1, 1'b0, 0, 0);
    pix_exp(163, 205, 1'b1, 1'b1, 0, 12'h17F);
    pix_exp(99, 205, 1'b1, 1'b0, 0, 0);
    pix_exp(100, 200, 1'b1, 1'b1, 0, 12'h000);
    pix_exp(110, 264, 1'b1, 1'b0, 0, 0);
    pix_exp(110, 263, 1'b1, 1'b1, 0, 12'hFCA);
    drain();
  endtask

  task automatic test_priority();
    write_slot(1, 50, 50, 1'b1);
    write_slot(2, 50, 50, 1'b1);
    drain();
    do_commit();
    pix_exp(60, 60, 1'b1, 1'b1, 1, 12'h28A);
    drain();
    check_coll("coll_set", COLL_ON);
    pix_exp(110, 205, 1'b1, 1'b1, 0, 12'h14A);
    drain();
    check_coll("coll_sticky", COLL_ON);
    do_commit();
    check_coll("coll_after_commit", 1'b0);
  endtask

  task automatic test_same_cycle();
    wr_valid = 1'b1; wr_slot = 2'd3; wr_posx = -10'sd10; wr_posy = 10'sd0; wr_en = 1'b1;
    sh_x[3] = -10; sh_y[3] = 0; sh_en[3] = 1'b1;
    do_commit();
    pix_exp(0, 0, 1'b1, 1'b1, 3, 12'h00A);
    pix_exp(-5, 0, 1'b1, 1'b1, 3, 12'h005);
    pix_exp(-11, 0, 1'b1, 1'b0, 0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      pix(int'($urandom_range(0, 240)) - 20, int'($urandom_range(0, 290)) - 20,
          $urandom_range(0, 3) != 0);
    drain();
  endtask

  task automatic test_reset_mid_commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    clear_model();
    check_idle_outputs("reset_mid_commit");
    pix_exp(110, 205, 1'b1, 1'b0, 0, 0);
    pix_exp(60, 60, 1'b1, 1'b0, 0, 0);
    pix_exp(0, 0, 1'b1, 1'b0, 0, 0);
    pix_exp(0, 0, 1'b1, 1'b0, 0, 0);
    drain();
    do_commit();
    pix_exp(110, 205, 1'b1, 1'b0, 0, 0);
    pix_exp(60, 60, 1'b1, 1'b0, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_priority();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
